// File: rtl/symb_timer.sv
// ---------------------------------------------------------------------------
// symb_timer
// Slices the Rx I/Q sample stream into N_SYMB OFDM symbols per frame, starting
// from the filtered frame-start strobe plus its fine delay. The cyclic prefix of
// each symbol is dropped and FFTSIZE-sample windows are forwarded with framing
// strobes to the FFT stage.
//
// Optional feature macro: SYMB_TIMER_CP_BACKOFF_EN
//   When defined, each window is placed CP_BACKOFF samples early inside the CP
//   (CPSIZE-CP_BACKOFF CP samples dropped before, CP_BACKOFF dropped after),
//   keeping the symbol period at FFTSIZE+CPSIZE.
//
// Ports:
//   clk, rst            sample clock, asynchronous active-high reset
//   isop                one-cycle frame-start strobe (SOP filter)
//   delay_sop[5:0]      signed fine delay, sampled with isop
//   found_sync          sync-lock level
//   i_valid, i_re, i_im input sample stream
//   o_valid, o_re, o_im window samples (registered, 1-cycle latency)
//   o_sos, o_eos, o_sof start/end of window, start of frame (symbol 0)
//   o_symb_idx          symbol index of current window, held between windows
//   o_busy              frame in progress
//   o_abort             one-cycle pulse when a window is truncated by resync
// ---------------------------------------------------------------------------
module symb_timer #(
    parameter int N_SYMB      = 50,
    parameter int FFTSIZE     = 1024,
    parameter int CPSIZE      = 32,
    parameter int DW          = 16,
    parameter int OFFSET_BASE = 32,
    parameter int CP_BACKOFF  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      isop,
    input  logic [5:0]                delay_sop,
    input  logic                      found_sync,
    input  logic                      i_valid,
    input  logic [DW-1:0]             i_re,
    input  logic [DW-1:0]             i_im,
    output logic                      o_valid,
    output logic [DW-1:0]             o_re,
    output logic [DW-1:0]             o_im,
    output logic                      o_sos,
    output logic                      o_eos,
    output logic                      o_sof,
    output logic [$clog2(N_SYMB)-1:0] o_symb_idx,
    output logic                      o_busy,
    output logic                      o_abort
);

    localparam int IW = $clog2(N_SYMB);
    localparam int WW = $clog2(OFFSET_BASE + 32) + 1;
    localparam int CW = $clog2(FFTSIZE + CPSIZE);

`ifdef SYMB_TIMER_CP_BACKOFF_EN
    localparam bit BACKOFF_EN = 1'b1;
`else
    localparam bit BACKOFF_EN = 1'b0;
`endif

    // Leading CP samples to drop, and trailing samples dropped after a window.
    localparam int CP_DROP  = BACKOFF_EN ? (CPSIZE - CP_BACKOFF) : CPSIZE;
    localparam int TAIL_LEN = BACKOFF_EN ? CP_BACKOFF : 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_CP   = 3'd2,
        S_DATA = 3'd3,
        S_TAIL = 3'd4
    } state_t;

    state_t          state_r, state_n;
    logic [WW-1:0]   wait_r, wait_n;
    logic [CW-1:0]   cnt_r, cnt_n;
    logic [IW-1:0]   idx_r, idx_n;
    logic [WW-1:0]   wait_w_s;
    logic            vld_s, sos_s, eos_s, sof_s, abort_s;

    // Offset base is >= 32 so the sign-extended sum can never go negative.
    assign wait_w_s = WW'(OFFSET_BASE) + {{(WW-6){delay_sop[5]}}, delay_sop};

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            wait_r  <= '0;
            cnt_r   <= '0;
            idx_r   <= '0;
        end else begin
            state_r <= state_n;
            wait_r  <= wait_n;
            cnt_r   <= cnt_n;
            idx_r   <= idx_n;
        end
    end

    // Next-state, counter and output-strobe decode.
    always_comb begin
        state_n = state_r;
        wait_n  = wait_r;
        cnt_n   = cnt_r;
        idx_n   = idx_r;
        vld_s   = 1'b0;
        sos_s   = 1'b0;
        eos_s   = 1'b0;
        abort_s = 1'b0;
        if (isop && found_sync) begin
            // Frame start or resync; the sample of this cycle is not counted.
            wait_n  = wait_w_s;
            cnt_n   = '0;
            idx_n   = '0;
            state_n = (wait_w_s == '0) ? S_CP : S_WAIT;
            abort_s = (state_r == S_DATA) && (cnt_r != '0);
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_n = S_IDLE;
                end
                S_WAIT: begin
                    if (!found_sync) begin
                        state_n = S_IDLE;
                    end else if (i_valid) begin
                        wait_n = wait_r - WW'(1);
                        if (wait_r == WW'(1)) begin
                            state_n = S_CP;
                            cnt_n   = '0;
                        end else begin
                            state_n = S_WAIT;
                        end
                    end else begin
                        state_n = S_WAIT;
                    end
                end
                S_CP: begin
                    if (!found_sync) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else if (i_valid) begin
                        if (cnt_r == CW'(CP_DROP - 1)) begin
                            state_n = S_DATA;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_r + CW'(1);
                        end
                    end else begin
                        state_n = S_CP;
                    end
                end
                S_DATA: begin
                    // Lock loss is only honoured at the window end.
                    if (i_valid) begin
                        vld_s = 1'b1;
                        sos_s = (cnt_r == '0);
                        eos_s = (cnt_r == CW'(FFTSIZE - 1));
                        if (eos_s) begin
                            cnt_n = '0;
                            if (!found_sync || (idx_r == IW'(N_SYMB - 1))) begin
                                state_n = S_IDLE;
                                idx_n   = '0;
                            end else begin
                                idx_n   = idx_r + IW'(1);
                                state_n = (TAIL_LEN != 0) ? S_TAIL : S_CP;
                            end
                        end else begin
                            cnt_n = cnt_r + CW'(1);
                        end
                    end else begin
                        state_n = S_DATA;
                    end
                end
                S_TAIL: begin
                    if (!found_sync) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else if (i_valid) begin
                        if (cnt_r == CW'(TAIL_LEN - 1)) begin
                            state_n = S_CP;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_r + CW'(1);
                        end
                    end else begin
                        state_n = S_TAIL;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end
        sof_s = sos_s && (idx_r == '0);
    end

    // Registered outputs; data and symbol index hold between windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_re       <= '0;
            o_im       <= '0;
            o_sos      <= 1'b0;
            o_eos      <= 1'b0;
            o_sof      <= 1'b0;
            o_symb_idx <= '0;
            o_busy     <= 1'b0;
            o_abort    <= 1'b0;
        end else begin
            o_valid <= vld_s;
            o_sos   <= sos_s;
            o_eos   <= eos_s;
            o_sof   <= sof_s;
            o_abort <= abort_s;
            o_busy  <= (state_r != S_IDLE);
            if (vld_s) begin
                o_re       <= i_re;
                o_im       <= i_im;
                o_symb_idx <= idx_r;
            end
        end
    end

endmodule
